// File: rtl/traffic_light_controller_new.sv
// +-----------------------------------------------------------------------------+
// | traffic_light_controller_new: fixed-time 4-way rotation (G -> Y -> all-red)  |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module traffic_light_controller_new #(
  parameter int GREEN_TIME  = 40,
  parameter int YELLOW_TIME = 10,
  parameter int ALLRED_TIME = 2,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light_path_left,
  output logic [2:0] light_path_right,
  output logic [2:0] light_straight,
  output logic [2:0] light_back
);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  // State = {approach[1:0], phase[1:0]}; phase 2'b11 is the unused encoding.
  localparam logic [1:0] PH_G   = 2'd0;
  localparam logic [1:0] PH_Y   = 2'd1;
  localparam logic [1:0] PH_AR  = 2'd2;
  localparam logic [1:0] PH_BAD = 2'd3;

  localparam logic [3:0] L_G  = 4'b00_00;
  localparam logic [3:0] L_Y  = 4'b00_01;
  localparam logic [3:0] L_AR = 4'b00_10;
  localparam logic [3:0] R_G  = 4'b01_00;
  localparam logic [3:0] R_Y  = 4'b01_01;
  localparam logic [3:0] R_AR = 4'b01_10;
  localparam logic [3:0] S_G  = 4'b10_00;
  localparam logic [3:0] S_Y  = 4'b10_01;
  localparam logic [3:0] S_AR = 4'b10_10;
  localparam logic [3:0] B_G  = 4'b11_00;
  localparam logic [3:0] B_Y  = 4'b11_01;
  localparam logic [3:0] B_AR = 4'b11_10;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [3:0]       state;
  logic [3:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_cnt;
  logic             advance;
  logic [2:0]       heads [4];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= L_G;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= advance ? '0 : cnt + CNT_ONE;
    end
  end

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    case (state[1:0])
      PH_G:    last_cnt = GREEN_LAST;
      PH_Y:    last_cnt = YELLOW_LAST;
      default: last_cnt = ALLRED_LAST;
    endcase
    if (state[1:0] == PH_BAD) begin
      state_next = L_G;
      advance    = 1'b1;
    end else if (cnt == last_cnt) begin
      advance = 1'b1;
      if (state[1:0] == PH_AR) begin
        state_next = {state[3:2] + 2'd1, PH_G};
      end else begin
        state_next = {state[3:2], state[1:0] + 2'd1};
      end
    end
  end

  // Decoded from the state register alone, so the counter cannot glitch a head.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      heads[i] = RED;
    end
    case (state[1:0])
      PH_G:    heads[state[3:2]] = GREEN;
      PH_Y:    heads[state[3:2]] = YELLOW;
      default: ;
    endcase
  end

  assign light_path_left  = heads[0];
  assign light_path_right = heads[1];
  assign light_straight   = heads[2];
  assign light_back       = heads[3];

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_controller_new.sv
// Bench for traffic_light_controller_new: default and 3/2/1 instances against a
// cycle-index model of the fixed rotation, plus reset and ordering sequences.
`default_nettype none

module tb_traffic_light_controller_new;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] d_left, d_right, d_straight, d_back;
  logic [2:0] s_left, s_right, s_straight, s_back;

  int total = 0;
  int bad   = 0;
  int t     = 0;
  int left_entries = 0;
  int last_app = 0;
  bit mon_on = 1'b0;
  logic [11:0] prev_d = 12'h924;

  typedef struct {
    int         t;
    logic [2:0] l, r, s, b;
  } vec_t;
  vec_t vecs [17];

  traffic_light_controller_new u_dut (
    .clk              (clk),
    .rst              (rst),
    .light_path_left  (d_left),
    .light_path_right (d_right),
    .light_straight   (d_straight),
    .light_back       (d_back)
  );

  traffic_light_controller_new #(
    .GREEN_TIME  (3),
    .YELLOW_TIME (2),
    .ALLRED_TIME (1),
    .CNT_W       (8)
  ) u_small (
    .clk              (clk),
    .rst              (rst),
    .light_path_left  (s_left),
    .light_path_right (s_right),
    .light_straight   (s_straight),
    .light_back       (s_back)
  );

  always #10 clk = ~clk;

  // Cycles since the last reset edge; 0 is the cycle right after a reset edge.
  always @(posedge clk) begin
    if (!rst) t <= 0;
    else      t <= t + 1;
  end

  initial begin
    #(20 * 20000);
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  function automatic logic [11:0] ref_lights(int tt, int g, int y, int a);
    logic [11:0] res;
    int per, pos, app, w;
    res = 12'b100_100_100_100;
    per = g + y + a;
    pos = tt % (4 * per);
    app = pos / per;
    w   = pos % per;
    if (w < g)          res[(3 - app) * 3 +: 3] = 3'b001;
    else if (w < g + y) res[(3 - app) * 3 +: 3] = 3'b010;
    return res;
  endfunction

  function automatic bit is_safe(logic [11:0] v);
    int nonred;
    bit ok;
    nonred = 0;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v[i*3 +: 3] != 3'b100) nonred++;
      if (v[i*3 +: 3] != 3'b100 && v[i*3 +: 3] != 3'b010 && v[i*3 +: 3] != 3'b001) ok = 1'b0;
    end
    return ok && (nonred <= 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", nm, act, exp, t, $time);
    end
  endtask

  // One cycle: advance to the next falling edge and run the per-cycle checks.
  task automatic tick();
    logic [11:0] cur_d, cur_s;
    @(negedge clk);
    cur_d = {d_left, d_right, d_straight, d_back};
    cur_s = {s_left, s_right, s_straight, s_back};
    if (mon_on) begin
      chk("model_default", cur_d, ref_lights(t, 40, 10, 2));
      chk("model_small", cur_s, ref_lights(t, 3, 2, 1));
      chk("safety_default", is_safe(cur_d), 1);
      chk("safety_small", is_safe(cur_s), 1);
      if (t == 0) begin
        last_app = 0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (cur_d[(3 - i) * 3 +: 3] == 3'b001 && prev_d[(3 - i) * 3 +: 3] != 3'b001) begin
            chk("order", i, (last_app + 1) % 4);
            last_app = i;
            if (i == 0) left_entries++;
          end
        end
      end
    end
    prev_d = cur_d;
  endtask

  task automatic wait_t(input int target);
    int n;
    n = 0;
    while (t != target && n < 1000) begin
      tick();
      n++;
    end
    if (t != target) chk("wait_t", t, target);
  endtask

  initial begin
    int green_len;
    int n;
    vecs[0]  = '{0,   3'b001, 3'b100, 3'b100, 3'b100};
    vecs[1]  = '{39,  3'b001, 3'b100, 3'b100, 3'b100};
    vecs[2]  = '{40,  3'b010, 3'b100, 3'b100, 3'b100};
    vecs[3]  = '{49,  3'b010, 3'b100, 3'b100, 3'b100};
    vecs[4]  = '{50,  3'b100, 3'b100, 3'b100, 3'b100};
    vecs[5]  = '{51,  3'b100, 3'b100, 3'b100, 3'b100};
    vecs[6]  = '{52,  3'b100, 3'b001, 3'b100, 3'b100};
    vecs[7]  = '{91,  3'b100, 3'b001, 3'b100, 3'b100};
    vecs[8]  = '{92,  3'b100, 3'b010, 3'b100, 3'b100};
    vecs[9]  = '{102, 3'b100, 3'b100, 3'b100, 3'b100};
    vecs[10] = '{104, 3'b100, 3'b100, 3'b001, 3'b100};
    vecs[11] = '{144, 3'b100, 3'b100, 3'b010, 3'b100};
    vecs[12] = '{156, 3'b100, 3'b100, 3'b100, 3'b001};
    vecs[13] = '{196, 3'b100, 3'b100, 3'b100, 3'b010};
    vecs[14] = '{206, 3'b100, 3'b100, 3'b100, 3'b100};
    vecs[15] = '{207, 3'b100, 3'b100, 3'b100, 3'b100};
    vecs[16] = '{208, 3'b001, 3'b100, 3'b100, 3'b100};

    rst = 1'b0;
    repeat (2) tick();
    mon_on = 1'b1;
    chk("reset_state", {d_left, d_right, d_straight, d_back}, 12'b001_100_100_100);
    chk("reset_state_small", {s_left, s_right, s_straight, s_back}, 12'b001_100_100_100);
    rst = 1'b1;
    left_entries = 1;

    for (int i = 0; i < 17; i++) begin
      wait_t(vecs[i].t);
      chk($sformatf("vec_t%0d", vecs[i].t), {d_left, d_right, d_straight, d_back},
          {vecs[i].l, vecs[i].r, vecs[i].s, vecs[i].b});
    end

    wait_t(499);
    chk("left_green_entries", left_entries, 3);

    n = 0;
    while (d_straight != 3'b010 && n < 300) begin
      tick();
      n++;
    end
    chk("straight_yellow_found", d_straight, 3'b010);
    rst = 1'b0;
    tick();
    chk("mid_reset", {d_left, d_right, d_straight, d_back}, 12'b001_100_100_100);
    rst = 1'b1;
    green_len = 1;
    while (d_left == 3'b001 && green_len < 100) begin
      tick();
      if (d_left == 3'b001) green_len++;
    end
    chk("left_green_len_after_reset", green_len, 40);

    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(1, 300)) tick();
      rst = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
      chk("random_reset", {d_left, d_right, d_straight, d_back}, 12'b001_100_100_100);
      rst = 1'b1;
    end

    repeat (60) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
